// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern controller.
// Mode codes match the two PS GPIO bits that software writes.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        BR_RISE = 1'b0,
        BR_FALL = 1'b1
    } breathe_t;

    localparam int DEFAULT_PRESCALE      = 390;
    localparam int DEFAULT_PWM_BITS      = 8;
    localparam int DEFAULT_BLINK_PERIODS = 250;
    localparam int DEFAULT_BREATHE_STEP  = 4;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Software-facing control/status bundle of the LED pattern controller.
// The master side is the PS GPIO driver; the slave side is the controller.
interface led_pattern_ctrl_if
    import led_pattern_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
);
    mode_t               mode_i;
    logic [PWM_BITS-1:0] bright_i;
    logic                led_o;
    mode_t               mode_o;
    logic                period_o;

    modport master (
        output mode_i,
        output bright_i,
        input  led_o,
        input  mode_o,
        input  period_o
    );

    modport slave (
        input  mode_i,
        input  bright_i,
        output led_o,
        output mode_o,
        output period_o
    );

endinterface

// File: rtl/led_pwm_core.sv
// PWM timebase: prescaler, PWM counter and duty comparator.
// pwm_on is combinational; the caller registers it to drive the pin.
module led_pwm_core
    import led_pattern_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                period_end,
    output logic                pwm_on
);

    localparam int                  PRESC_W    = count_width(PRESCALE);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;

    logic [PRESC_W-1:0]  prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;

    assign tick       = (prescaler == PRESC_LAST);
    assign period_end = tick && (pwm_cnt == CNT_MAX);
    assign pwm_on     = (pwm_cnt < duty);

    // pwm_cnt relies on natural wrap from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: OFF / ON / BLINK / BREATHE on top of a PWM core.
// Mode and duty are only ever updated at PWM period boundaries.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int PRESCALE      = DEFAULT_PRESCALE,
    parameter int PWM_BITS      = DEFAULT_PWM_BITS,
    parameter int BLINK_PERIODS = DEFAULT_BLINK_PERIODS,
    parameter int BREATHE_STEP  = DEFAULT_BREATHE_STEP
) (
    input logic               clk,
    input logic               rst,
    led_pattern_ctrl_if.slave bus
);

    localparam int                  BLINK_W    = count_width(BLINK_PERIODS);
    localparam int                  STEP_W     = count_width(BREATHE_STEP);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(BREATHE_STEP - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

    mode_t               mode_q;
    mode_t               eff_mode;
    logic [PWM_BITS-1:0] duty_q;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    breathe_t            br_state;
    logic [STEP_W-1:0]   step_cnt;
    logic                led_q;
    logic                led_next;
    logic                period_q;
    logic                period_end;
    logic                pwm_on;
    logic                mode_change;

    led_pwm_core #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .duty       (duty_q),
        .period_end (period_end),
        .pwm_on     (pwm_on)
    );

    assign mode_change = (bus.mode_i != mode_q);

    // Looking ahead at the boundary lets ON/OFF switch on the same edge that updates mode_o.
    assign eff_mode = period_end ? bus.mode_i : mode_q;

    always_comb begin
        led_next = 1'b0;
        case (eff_mode)
            MODE_OFF: led_next = 1'b0;
            MODE_ON:  led_next = 1'b1;
            default:  led_next = pwm_on;
        endcase
    end

    // Pattern state machine; entering a mode restarts that mode's own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_OFF;
            duty_q      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            br_state    <= BR_RISE;
            step_cnt    <= '0;
            led_q       <= 1'b0;
            period_q    <= 1'b0;
        end else begin
            period_q <= period_end;
            led_q    <= led_next;
            if (period_end) begin
                mode_q <= bus.mode_i;
                case (bus.mode_i)
                    MODE_BLINK: begin
                        if (mode_change) begin
                            blink_phase <= 1'b1;
                            blink_cnt   <= '0;
                            duty_q      <= bus.bright_i;
                        end else if (blink_cnt == BLINK_LAST) begin
                            blink_cnt   <= '0;
                            blink_phase <= ~blink_phase;
                            duty_q      <= blink_phase ? '0 : bus.bright_i;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                            duty_q    <= blink_phase ? bus.bright_i : '0;
                        end
                    end
                    MODE_BREATHE: begin
                        if (mode_change) begin
                            duty_q   <= '0;
                            br_state <= BR_RISE;
                            step_cnt <= '0;
                        end else if (step_cnt != STEP_LAST) begin
                            step_cnt <= step_cnt + 1'b1;
                        end else begin
                            step_cnt <= '0;
                            // The turnaround step holds the end value rather than wrapping.
                            case (br_state)
                                BR_RISE: begin
                                    if (duty_q == DUTY_MAX) br_state <= BR_FALL;
                                    else                    duty_q   <= duty_q + 1'b1;
                                end
                                BR_FALL: begin
                                    if (duty_q == '0) br_state <= BR_RISE;
                                    else              duty_q   <= duty_q - 1'b1;
                                end
                            endcase
                        end
                    end
                    default: duty_q <= '0;
                endcase
            end
        end
    end

    assign bus.led_o    = led_q;
    assign bus.mode_o   = mode_q;
    assign bus.period_o = period_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a small PWM configuration.
// Each observation window is one PWM period, starting at a period_o pulse.
module tb_led_pattern_ctrl;
    import led_pattern_pkg::*;

    localparam int PRESCALE      = 2;
    localparam int PWM_BITS      = 4;
    localparam int BLINK_PERIODS = 2;
    localparam int BREATHE_STEP  = 1;
    localparam int PERIOD        = 32;

    logic clk = 1'b0;
    logic rst;

    led_pattern_ctrl_if #(.PWM_BITS(PWM_BITS)) bus ();

    led_pattern_ctrl #(
        .PRESCALE      (PRESCALE),
        .PWM_BITS      (PWM_BITS),
        .BLINK_PERIODS (BLINK_PERIODS),
        .BREATHE_STEP  (BREATHE_STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        mode_t      mode;
        logic [3:0] bright;
        int         exp_high;
        mode_t      exp_mode;
    } vec_t;

    vec_t vecs[$];
    int   vec_count   = 0;
    int   miscompares = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives inputs, waits for the boundary that samples them, then counts led_o over one period.
    // Optional mid-window input change at sample chg_at, restored to m/b at sample rev_at.
    task automatic apply_stimulus(input mode_t m, input logic [3:0] b,
                                  input int chg_at, input mode_t m2, input logic [3:0] b2,
                                  input int rev_at,
                                  output int high, output mode_t mode_seen);
        int waited;
        waited     = 0;
        high       = 0;
        mode_seen  = MODE_OFF;
        bus.mode_i   = m;
        bus.bright_i = b;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.period_o && waited < 2 * PERIOD);
        if (!bus.period_o) begin
            check_output("period_o timeout", 0, 1);
            return;
        end
        mode_seen = bus.mode_o;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            high += int'(bus.led_o);
            if (i == chg_at) begin
                bus.mode_i   = m2;
                bus.bright_i = b2;
            end
            if (i == rev_at) begin
                bus.mode_i   = m;
                bus.bright_i = b;
            end
        end
    endtask

    task automatic run_window(input string name, input mode_t m, input logic [3:0] b,
                              input int exp_high, input mode_t exp_mode);
        int    high;
        mode_t ms;
        apply_stimulus(m, b, -1, m, b, -1, high, ms);
        check_output({name, " high"}, high, exp_high);
        check_output({name, " mode_o"}, int'(ms), int'(exp_mode));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    high;
        int    n;
        int    errs;
        mode_t ms;

        vecs.push_back('{MODE_ON,      4'd0,  32, MODE_ON});
        vecs.push_back('{MODE_OFF,     4'd0,   0, MODE_OFF});
        vecs.push_back('{MODE_BLINK,   4'd15, 30, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd15, 30, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd15,  0, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd15,  0, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd15, 30, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd5,  10, MODE_BLINK});
        vecs.push_back('{MODE_BLINK,   4'd5,   0, MODE_BLINK});
        vecs.push_back('{MODE_ON,      4'd5,  32, MODE_ON});
        vecs.push_back('{MODE_BLINK,   4'd1,   2, MODE_BLINK});
        vecs.push_back('{MODE_BREATHE, 4'd9,   0, MODE_BREATHE});
        vecs.push_back('{MODE_BREATHE, 4'd9,   2, MODE_BREATHE});
        vecs.push_back('{MODE_BREATHE, 4'd9,   4, MODE_BREATHE});
        vecs.push_back('{MODE_OFF,     4'd9,   0, MODE_OFF});

        bus.mode_i   = MODE_OFF;
        bus.bright_i = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset led_o", int'(bus.led_o), 0);
        check_output("reset mode_o", int'(bus.mode_o), int'(MODE_OFF));
        check_output("reset period_o", int'(bus.period_o), 0);
        rst = 1'b0;

        // ON requested at cycle 5: first period_o is cycle 32, led_o rises with it.
        repeat (5) @(negedge clk);
        bus.mode_i = MODE_ON;
        n    = 5;
        errs = 0;
        while (!bus.period_o && n < 100) begin
            errs += int'(bus.led_o);
            @(negedge clk);
            n++;
        end
        check_output("on first period_o cycle", n, 32);
        check_output("on led_o low before boundary", errs, 0);
        check_output("on led_o at boundary", int'(bus.led_o), 1);
        check_output("on mode_o at boundary", int'(bus.mode_o), int'(MODE_ON));
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            errs += int'(!bus.led_o);
        end
        check_output("on led_o held", errs, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_window($sformatf("vec%0d", i), vecs[i].mode, vecs[i].bright,
                       vecs[i].exp_high, vecs[i].exp_mode);
        end

        // Breathe triangle: 0,2,...,30, then 30 held, then down to 0.
        for (int k = 0; k < 32; k++) begin
            run_window($sformatf("breathe%0d", k), MODE_BREATHE, 4'd0,
                       (k <= 15) ? 2 * k : 2 * (31 - k), MODE_BREATHE);
        end

        // Reset while breathing with led_o high.
        n = 0;
        while (!bus.led_o && n < 10 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check_output("breathe led_o high before reset", int'(bus.led_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst led_o", int'(bus.led_o), 0);
        check_output("midrst mode_o", int'(bus.mode_o), int'(MODE_OFF));
        check_output("midrst period_o", int'(bus.period_o), 0);
        n    = 0;
        errs = 0;
        do begin
            @(negedge clk);
            n++;
            errs += int'(bus.led_o);
        end while (!bus.period_o && n < 2 * PERIOD);
        check_output("midrst first period_o delay", n, 32);
        check_output("midrst led_o low", errs, 0);
        check_output("midrst mode_o after boundary", int'(bus.mode_o), int'(MODE_BREATHE));

        // BLINK with zero brightness, then raise it mid-window.
        run_window("blink0 on1", MODE_BLINK, 4'd0, 0, MODE_BLINK);
        apply_stimulus(MODE_BLINK, 4'd0, 10, MODE_BLINK, 4'd8, -1, high, ms);
        check_output("blink0 on2 high", high, 0);
        check_output("blink0 on2 mode_o", int'(ms), int'(MODE_BLINK));
        run_window("blink8 off1", MODE_BLINK, 4'd8, 0, MODE_BLINK);
        run_window("blink8 off2", MODE_BLINK, 4'd8, 0, MODE_BLINK);
        run_window("blink8 on1", MODE_BLINK, 4'd8, 16, MODE_BLINK);
        run_window("blink8 on2", MODE_BLINK, 4'd8, 16, MODE_BLINK);
        run_window("blink8 off3", MODE_BLINK, 4'd8, 0, MODE_BLINK);

        // OFF -> ON -> OFF inside one period must leave no trace.
        run_window("glitch pre", MODE_OFF, 4'd0, 0, MODE_OFF);
        apply_stimulus(MODE_OFF, 4'd0, 5, MODE_ON, 4'd0, 20, high, ms);
        check_output("glitch window high", high, 0);
        check_output("glitch window mode_o", int'(ms), int'(MODE_OFF));
        run_window("glitch post", MODE_OFF, 4'd0, 0, MODE_OFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
